// File: rtl/ex_pkg.sv
// Shared decode constants, ALU control and MDU state encodings for the execute stage.
package ex_pkg;

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;

    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MFHI, ALU_MFLO, ALU_NOP
    } aluCtrl_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mduState_t;

endpackage

// File: rtl/ex_mdu.sv
// Iterative unsigned multiply/divide with HI/LO (shift-add / restoring divide, one bit per cycle).
// Built only with EX_MDU_EN defined; otherwise busy and HI/LO are tied to zero.
module ex_mdu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             isDiv,
    input  logic             flush,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import ex_pkg::*;

`ifdef EX_MDU_EN
    localparam int CW = $clog2(WIDTH);

    mduState_t        state, stateNext;
    logic [CW-1:0]    count;
    logic             divMode;
    logic [WIDTH-1:0] opBReg, accHi, accLo, stepHi, stepLo;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH+1:0] divDiff;
    logic             divByZero;

    assign divByZero = isDiv && (opB == '0);

    // One iteration: {accHi,accLo} is the product accumulator or {remainder,quotient}.
    always_comb begin
        mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, opBReg} : {(WIDTH+1){1'b0}});
        divDiff = {1'b0, accHi, accLo[WIDTH-1]} - {2'b00, opBReg};
        stepHi  = mulSum[WIDTH:1];
        stepLo  = {mulSum[0], accLo[WIDTH-1:1]};
        if (divMode) begin
            if (divDiff[WIDTH+1]) begin
                stepHi = {accHi[WIDTH-2:0], accLo[WIDTH-1]};
                stepLo = {accLo[WIDTH-2:0], 1'b0};
            end else begin
                stepHi = divDiff[WIDTH-1:0];
                stepLo = {accLo[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        case (state)
            MDU_IDLE: if (start) begin
                busy      = 1'b1;
                stateNext = divByZero ? MDU_DONE : MDU_RUN;
            end
            MDU_RUN: begin
                if (flush) stateNext = MDU_IDLE;
                else begin
                    busy = 1'b1;
                    if (count == '0) stateNext = MDU_DONE;
                end
            end
            MDU_DONE: stateNext = MDU_IDLE;
            default:  stateNext = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MDU_IDLE;
            count   <= '0;
            divMode <= 1'b0;
            opBReg  <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= stateNext;
            case (state)
                MDU_IDLE: if (start) begin
                    divMode <= isDiv;
                    opBReg  <= opB;
                    accHi   <= '0;
                    accLo   <= opA;
                    count   <= CW'(WIDTH - 1);
                    if (divByZero) begin
                        hi <= opA;
                        lo <= '1;
                    end
                end
                MDU_RUN: if (!flush) begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        hi <= stepHi;
                        lo <= stepLo;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unusedInputs;
    assign unusedInputs = ^{clock, reset_n, start, isDiv, flush, opA, opB};
    assign busy = 1'b0;
    assign hi   = '0;
    assign lo   = '0;
`endif

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding muxes, ALU, branch-target adder, EX/MEM register and MDU.
// Define EX_MDU_EN to build the MDU with MULTU/DIVU/MFHI/MFLO.
module ex_stage_mdu #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      pc4,
    input  logic [WIDTH-1:0]      rs_data,
    input  logic [WIDTH-1:0]      rt_data,
    input  logic [WIDTH-1:0]      imm,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  alu_src,
    input  logic [1:0]            alu_op,
    input  logic                  reg_dest,
    input  logic [1:0]            fwd_a,
    input  logic [1:0]            fwd_b,
    input  logic [WIDTH-1:0]      fwd_mem,
    input  logic [WIDTH-1:0]      fwd_wb,
    output logic                  stall_o,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      alu_result,
    output logic                  zero,
    output logic [WIDTH-1:0]      branch_target,
    output logic [WIDTH-1:0]      store_data,
    output logic [REG_ADDR_W-1:0] dest_reg
);
    import ex_pkg::*;

    aluCtrl_t         aluCtrl;
    logic [WIDTH-1:0] opA, opB, aluB, aluRes, hi, lo;
    logic             isMul, isDiv, isMdu, mduStart;

    always_comb begin
        opA = rs_data;
        opB = rt_data;
        case (fwd_a)
            FWD_MEM: opA = fwd_mem;
            FWD_WB:  opA = fwd_wb;
            default: ;
        endcase
        case (fwd_b)
            FWD_MEM: opB = fwd_mem;
            FWD_WB:  opB = fwd_wb;
            default: ;
        endcase
    end

    assign aluB = alu_src ? imm : opB;

    always_comb begin
        aluCtrl = ALU_NOP;
        isMul   = 1'b0;
        isDiv   = 1'b0;
        case (alu_op)
            OP_ADD: aluCtrl = ALU_ADD;
            OP_SUB: aluCtrl = ALU_SUB;
            OP_RTYPE: case (imm[5:0])
                F_ADD: aluCtrl = ALU_ADD;
                F_SUB: aluCtrl = ALU_SUB;
                F_AND: aluCtrl = ALU_AND;
                F_OR:  aluCtrl = ALU_OR;
                F_SLT: aluCtrl = ALU_SLT;
`ifdef EX_MDU_EN
                F_MFHI:  aluCtrl = ALU_MFHI;
                F_MFLO:  aluCtrl = ALU_MFLO;
                F_MULTU: isMul   = 1'b1;
                F_DIVU:  isDiv   = 1'b1;
`endif
                default: aluCtrl = ALU_NOP;
            endcase
            default: aluCtrl = ALU_NOP;
        endcase
    end

    always_comb begin
        aluRes = '0;
        case (aluCtrl)
            ALU_ADD:  aluRes = opA + aluB;
            ALU_SUB:  aluRes = opA - aluB;
            ALU_AND:  aluRes = opA & aluB;
            ALU_OR:   aluRes = opA | aluB;
            ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, (opA < aluB)};
            ALU_MFHI: aluRes = hi;
            ALU_MFLO: aluRes = lo;
            default:  aluRes = '0;
        endcase
    end

    assign isMdu = isMul | isDiv;
    // Gating with reset_n keeps stall_o low while reset is held.
    assign mduStart = reset_n & valid_in & isMdu & ~flush;

    ex_mdu #(.WIDTH(WIDTH)) uMdu (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mduStart),
        .isDiv   (isDiv),
        .flush   (flush),
        .opA     (opA),
        .opB     (opB),
        .busy    (stall_o),
        .hi      (hi),
        .lo      (lo)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_out     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
            store_data    <= '0;
            dest_reg      <= '0;
        end else if (!stall_o) begin
            valid_out     <= valid_in & ~flush;
            alu_result    <= aluRes;
            zero          <= (aluRes == '0);
            branch_target <= pc4 + imm;
            store_data    <= opB;
            dest_reg      <= isMdu ? '0 : (reg_dest ? rd : rt);
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed plus randomized bench for ex_stage_mdu against an arithmetic reference model.
module tb_ex_stage_mdu;
    localparam int W  = 16;
    localparam int RA = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid_in, flush, alu_src, reg_dest;
    logic [W-1:0]  pc4, rs_data, rt_data, imm, fwd_mem, fwd_wb;
    logic [RA-1:0] rt, rd;
    logic [1:0]    alu_op, fwd_a, fwd_b;
    logic          stall_o, valid_out, zero;
    logic [W-1:0]  alu_result, branch_target, store_data;
    logic [RA-1:0] dest_reg;

    int passed = 0;
    int total  = 0;
    logic [W-1:0] mHi = '0;
    logic [W-1:0] mLo = '0;
    logic [5:0] functs [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h00, 6'h3F, 6'h21};

    always #5 clock = ~clock;

    ex_stage_mdu #(.WIDTH(W), .REG_ADDR_W(RA)) dut (
        .clock(clock), .reset_n(reset_n), .valid_in(valid_in), .flush(flush),
        .pc4(pc4), .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .rt(rt), .rd(rd),
        .alu_src(alu_src), .alu_op(alu_op), .reg_dest(reg_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .stall_o(stall_o), .valid_out(valid_out),
        .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
        .store_data(store_data), .dest_reg(dest_reg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] fwdVal(input logic [1:0] s, input logic [W-1:0] r);
        if (s == 2'b10) return fwd_mem;
        if (s == 2'b01) return fwd_wb;
        return r;
    endfunction

    function automatic logic [W-1:0] refResult();
        logic [W-1:0] a, b;
        a = fwdVal(fwd_a, rs_data);
        b = alu_src ? imm : fwdVal(fwd_b, rt_data);
        if (alu_op == 2'd0) return a + b;
        if (alu_op == 2'd1) return a - b;
        if (alu_op != 2'd2) return '0;
        case (imm[5:0])
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return (a < b) ? 16'd1 : 16'd0;
`ifdef EX_MDU_EN
            6'h10: return mHi;
            6'h12: return mLo;
`endif
            default: return '0;
        endcase
    endfunction

    // Single-cycle instruction: no stall, then every EX/MEM field after one edge.
    task automatic stepAlu(input string tag);
        logic [W-1:0] er, eb, es;
        logic [RA-1:0] ed;
        logic ev;
        #1;
        er = refResult();
        eb = pc4 + imm;
        es = fwdVal(fwd_b, rt_data);
        ed = reg_dest ? rd : rt;
        ev = valid_in & ~flush;
        chk({tag, "_stall"}, stall_o, 0);
        tick();
        chk({tag, "_res"}, alu_result, er);
        chk({tag, "_zero"}, zero, (er == '0));
        chk({tag, "_bt"}, branch_target, eb);
        chk({tag, "_sd"}, store_data, es);
        chk({tag, "_dest"}, dest_reg, ed);
        chk({tag, "_valid"}, valid_out, ev);
    endtask

    task automatic setR(input logic [5:0] f);
        valid_in = 1'b1; flush = 1'b0; alu_op = 2'd2; alu_src = 1'b0;
        fwd_a = 2'd0; fwd_b = 2'd0; reg_dest = 1'b1; rd = 5'd9; rt = 5'd4;
        imm = {10'h0, f};
    endtask

    task automatic readHL(input string tag, input logic [W-1:0] eHi, input logic [W-1:0] eLo);
        setR(6'h10);
        stepAlu({tag, "_mfhi"});
        chk({tag, "_hi"}, alu_result, eHi);
        setR(6'h12);
        stepAlu({tag, "_mflo"});
        chk({tag, "_lo"}, alu_result, eLo);
    endtask

`ifdef EX_MDU_EN
    task automatic runMdu(input string tag, input logic dv, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int expStall);
        int n;
        n = 0;
        setR(dv ? 6'h1B : 6'h19);
        rd = 5'd11; rs_data = a; rt_data = b;
        #1;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_stallcnt"}, n, expStall);
        tick();
        chk({tag, "_dest0"}, dest_reg, 0);
        chk({tag, "_valid"}, valid_out, 1);
        if (dv) begin
            if (b == '0) begin mLo = '1; mHi = a; end
            else begin mLo = a / b; mHi = a % b; end
        end else begin
            {mHi, mLo} = 32'(a) * 32'(b);
        end
    endtask
`endif

    initial begin
        valid_in = 0; flush = 0; pc4 = 0; rs_data = 0; rt_data = 0; imm = 0; rt = 0; rd = 0;
        alu_src = 0; alu_op = 0; reg_dest = 0; fwd_a = 0; fwd_b = 0; fwd_mem = 0; fwd_wb = 0;
        #2;
        chk("rst_res", alu_result, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_zero", zero, 0);
        chk("rst_bt", branch_target, 0);
        chk("rst_dest", dest_reg, 0);
        chk("rst_stall", stall_o, 0);
        tick();
        reset_n = 1'b1;

        // ADD with operand A forwarded from MEM
        setR(6'h20); fwd_a = 2'b10; fwd_mem = 16'h0005; rs_data = 16'h1234; rt_data = 16'h0003;
        rd = 5'd7; pc4 = 16'h0040;
        stepAlu("add_fwd");
        chk("add_val", alu_result, 16'h0008);
        chk("add_rd", dest_reg, 7);

        // SUB with immediate gives zero
        valid_in = 1; alu_op = 2'd1; alu_src = 1; fwd_a = 0; rs_data = 16'h0010;
        imm = 16'h0010; pc4 = 16'h0100; reg_dest = 0; rt = 5'd3;
        stepAlu("sub_imm");
        chk("sub_zero", zero, 1);
        chk("sub_bt", branch_target, 16'h0110);

        for (int i = 0; i < 30; i++) begin
            valid_in = 1'($urandom_range(0, 3) != 0);
            flush    = 1'($urandom_range(0, 5) == 0);
            alu_op   = 2'($urandom_range(0, 2));
            alu_src  = 1'($urandom);
            reg_dest = 1'($urandom);
            fwd_a    = 2'($urandom);
            fwd_b    = 2'($urandom);
            rs_data  = 16'($urandom);
            rt_data  = (i % 5 == 0) ? rs_data : 16'($urandom);
            fwd_mem  = 16'($urandom);
            fwd_wb   = 16'($urandom);
            pc4      = 16'($urandom);
            imm      = {10'($urandom), functs[$urandom_range(0, 9)]};
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            stepAlu($sformatf("rnd%0d", i));
        end

`ifdef EX_MDU_EN
        runMdu("mul_max", 1'b0, 16'hFFFF, 16'hFFFF, W + 1);
        readHL("mul_max", 16'hFFFE, 16'h0001);
        runMdu("div_1000_7", 1'b1, 16'd1000, 16'd7, W + 1);
        readHL("div_1000_7", 16'h0006, 16'h008E);
        runMdu("div_zero", 1'b1, 16'd5, 16'd0, 1);
        readHL("div_zero", 16'h0005, 16'hFFFF);
        runMdu("mul_rnd", 1'b0, 16'($urandom), 16'($urandom), W + 1);
        readHL("mul_rnd", mHi, mLo);

        // Flush during RUN cycle 4: HI/LO must keep their prior values
        setR(6'h19); rs_data = 16'd300; rt_data = 16'd200;
        #1;
        chk("flush_start_stall", stall_o, 1);
        repeat (4) tick();
        flush = 1'b1;
        #1;
        chk("flush_stall_low", stall_o, 0);
        tick();
        chk("flush_valid", valid_out, 0);
        readHL("after_flush", mHi, mLo);
`else
        // Without the MDU these funct codes are unknown: result 0, one cycle
        setR(6'h19); rs_data = 16'hFFFF; rt_data = 16'hFFFF;
        stepAlu("multu_off");
        chk("multu_off_res", alu_result, 0);
        chk("multu_off_rd", dest_reg, 9);
        setR(6'h1B); rs_data = 16'd5; rt_data = 16'd0;
        stepAlu("divu_off");
`endif

        // Asynchronous reset, mid-operation when the MDU is present
        setR(6'h20); rs_data = 16'h0011; rt_data = 16'h0022; pc4 = 16'h0200;
        stepAlu("pre_rst");
`ifdef EX_MDU_EN
        setR(6'h19); rs_data = 16'd300; rt_data = 16'd200;
        #1;
        repeat (8) tick();
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_res", alu_result, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_bt", branch_target, 0);
        chk("arst_sd", store_data, 0);
        chk("arst_dest", dest_reg, 0);
        chk("arst_stall", stall_o, 0);
        tick();
        tick();
        setR(6'h10);
        reset_n = 1'b1;
        mHi = '0;
        mLo = '0;
        readHL("post_rst", 16'h0000, 16'h0000);
        setR(6'h20); rs_data = 16'h7000; rt_data = 16'h1001; rd = 5'd13;
        stepAlu("post_rst_add");
        chk("post_rst_add_val", alu_result, 16'h8001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
